// File: rtl/lsu_pkg.sv
// Shared load/store definitions: funct3 encodings, the per-access tag, and
// the load alignment / access legality helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef struct packed {
        logic       valid;
        logic       we;
        logic [2:0] funct3;
        logic [1:0] off;
        logic       err;
    } lsu_tag_t;

    function automatic logic req_err(input logic we, input logic [2:0] f3, input logic [1:0] off);
        logic bad_f3;
        logic misalign;
        bad_f3   = we ? (f3 > F3_W) : (f3 == 3'b011 || f3[2:1] == 2'b11);
        misalign = (f3[1:0] == 2'b01 && off[0]) || (f3[1:0] == 2'b10 && off != 2'b00);
        return bad_f3 || misalign;
    endfunction

    function automatic logic [31:0] load_align(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] d);
        logic [31:0] sh;
        logic [15:0] h;
        sh = d >> {off, 3'b000};
        h  = off[1] ? d[31:16] : d[15:0];
        case (f3)
            F3_B:    return {{24{sh[7]}}, sh[7:0]};
            F3_BU:   return {24'b0, sh[7:0]};
            F3_H:    return {{16{h[15]}}, h};
            F3_HU:   return {16'b0, h};
            F3_W:    return d;
            default: return 32'b0;
        endcase
    endfunction

endpackage

// File: rtl/data_lsu_if.sv
// Core request/response handshake plus the single data-memory port.
interface data_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_cen;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic [31:0] mem_data;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, mem_data,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_cen, mem_addr, mem_wmask, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, mem_data,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_cen, mem_addr, mem_wmask, mem_wdata
    );
endinterface

// File: rtl/lsu_rsp_fifo.sv
// Ordered response FIFO; DEPTH must be a power of two so pointers wrap freely.
// Read data is forced to zero while empty.
module lsu_rsp_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 33
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [W-1:0]               wdata,
    input  logic                       pop,
    output logic [W-1:0]               rdata,
    output logic                       valid,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  slot_q [DEPTH];
    logic [W-1:0]  slot_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          pop_en;

    assign valid  = (count_q != '0);
    assign pop_en = pop && valid;
    assign rdata  = valid ? slot_q[rd_ptr_q] : '0;
    assign count  = count_q;

    always_comb begin
        slot_d   = slot_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            slot_d[wr_ptr_q] = wdata;
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end
        if (pop_en) rd_ptr_d = rd_ptr_q + PW'(1);
        if (push && !pop_en)      count_d = count_q + CW'(1);
        else if (!push && pop_en) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) slot_q <= slot_d;

endmodule

// File: rtl/data_lsu.sv
// RV32I load/store unit: word-port access generation, fixed-latency tag
// pipeline and credit-controlled ordered response FIFO.
module data_lsu
    import lsu_pkg::*;
#(
    parameter int READ_LATENCY = 1,
    parameter int RSP_DEPTH    = 4
) (
    input  logic       clk,
    input  logic       reset,
    data_lsu_if.slave  bus
);
    localparam int CW = $clog2(RSP_DEPTH+1);
    localparam int IW = $clog2(RSP_DEPTH+READ_LATENCY+1);

    lsu_tag_t      tag_q [READ_LATENCY];
    lsu_tag_t      tag_d [READ_LATENCY];
    lsu_tag_t      last_tag;
    logic [CW-1:0] fifo_count;
    logic [IW-1:0] inflight;
    logic          fire, err, push, pop, fifo_valid;
    logic [3:0]    mask;
    logic [31:0]   wdata_rep, push_rdata;
    logic [32:0]   fifo_rdata;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) inflight = inflight + IW'(tag_q[i].valid);
    end

    // Credits cover both in-flight tags and queued responses, so the FIFO never overflows.
    assign bus.req_ready = !reset && ((inflight + IW'(fifo_count)) < IW'(RSP_DEPTH));
    assign fire          = bus.req_valid && bus.req_ready;
    assign err           = req_err(bus.req_we, bus.req_funct3, bus.req_addr[1:0]);

    always_comb begin
        case (bus.req_funct3[1:0])
            2'b00: begin
                mask      = 4'b0001 << bus.req_addr[1:0];
                wdata_rep = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                mask      = 4'b0011 << bus.req_addr[1:0];
                wdata_rep = {2{bus.req_wdata[15:0]}};
            end
            default: begin
                mask      = 4'b1111;
                wdata_rep = bus.req_wdata;
            end
        endcase
    end

    assign bus.mem_cen   = fire && !err;
    assign bus.mem_wmask = (bus.mem_cen && bus.req_we) ? mask : 4'b0000;
    assign bus.mem_addr  = {bus.req_addr[31:2], 2'b00};
    assign bus.mem_wdata = wdata_rep;

    always_comb begin
        tag_d[0].valid  = fire;
        tag_d[0].we     = bus.req_we;
        tag_d[0].funct3 = bus.req_funct3;
        tag_d[0].off    = bus.req_addr[1:0];
        tag_d[0].err    = err;
        for (int i = 1; i < READ_LATENCY; i++) tag_d[i] = tag_q[i-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < READ_LATENCY; i++) tag_q[i] <= '0;
        end else begin
            tag_q <= tag_d;
        end
    end

    // Error responses ride the same pipeline as real accesses to keep order.
    assign last_tag   = tag_q[READ_LATENCY-1];
    assign push       = last_tag.valid;
    assign push_rdata = (last_tag.we || last_tag.err) ? 32'b0
                      : load_align(last_tag.funct3, last_tag.off, bus.mem_data);
    assign pop        = bus.rsp_valid && bus.rsp_ready;

    lsu_rsp_fifo #(.DEPTH(RSP_DEPTH), .W(33)) u_rsp_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata ({push_rdata, last_tag.err}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .valid (fifo_valid),
        .count (fifo_count)
    );

    assign bus.rsp_valid = fifo_valid;
    assign bus.rsp_rdata = fifo_rdata[32:1];
    assign bus.rsp_err   = fifo_rdata[0];

endmodule

// File: tb/tb_data_lsu.sv
// Directed bench for data_lsu with a registered memory model and an ordered
// response scoreboard.
module tb_data_lsu;
    import lsu_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    data_lsu_if bus ();

    data_lsu #(.READ_LATENCY(1), .RSP_DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // One-cycle registered memory; reset reloads the known contents.
    logic [31:0] mem [256];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++)
                mem[i] <= (i == 64) ? 32'h8899AABC : (32'hC0DE0000 | 32'(i));
            bus.mem_data <= '0;
        end else if (bus.mem_cen) begin
            for (int b = 0; b < 4; b++)
                if (bus.mem_wmask[b]) mem[bus.mem_addr[9:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            bus.mem_data <= mem[bus.mem_addr[9:2]];
        end
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
        bit          chk_lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   last_fire = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && bus.rsp_valid && bus.rsp_ready) begin
            n_assert++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_rsp: observed response rdata %08h err %0b, expected none",
                       bus.rsp_rdata, bus.rsp_err);
            end
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("rsp_rdata", bus.rsp_rdata, mon_e.rdata);
                chk("rsp_err", 32'(bus.rsp_err), 32'(mon_e.err));
                if (mon_e.chk_lat) chk("rsp_latency", 32'(cyc - mon_e.cyc), 32'd2);
            end
        end
    end

    task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_err,
                        input logic [3:0] exp_wm, input logic [31:0] exp_mwd, input bit chk_lat,
                        input string tag);
        int w = 0;
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        @(negedge clk);
        while (!bus.req_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        n_assert++;
        assert (bus.req_ready) else begin
            n_fail++;
            $error("FAIL %s_fire: req_ready observed 0 after %0d cycles, expected 1", tag, w);
        end
        if (bus.req_ready) begin
            chk({tag, "_cen"}, 32'(bus.mem_cen), 32'(!exp_err));
            chk({tag, "_wmask"}, 32'(bus.mem_wmask), 32'(exp_wm));
            chk({tag, "_maddr"}, bus.mem_addr, {addr[31:2], 2'b00});
            if (we && !exp_err) chk({tag, "_mwdata"}, bus.mem_wdata, exp_mwd);
            sb.push_back('{exp_rd, exp_err, cyc, chk_lat});
            last_fire = cyc;
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while (sb.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation observed still running, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int prev;
        int nf;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.rsp_ready  = 1'b0;
        reset          = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_mem_cen", 32'(bus.mem_cen), 32'd0);
        chk("rst_mem_wmask", 32'(bus.mem_wmask), 32'd0);

        @(posedge clk); #1;
        reset         = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;

        // Load extension and alignment on word 0x8899AABC.
        send(0, F3_B,  32'h101, 0, 32'hFFFFFFAA, 0, 4'b0000, 0, 0, "lb");
        send(0, F3_BU, 32'h101, 0, 32'h000000AA, 0, 4'b0000, 0, 0, "lbu");
        send(0, F3_H,  32'h102, 0, 32'hFFFF8899, 0, 4'b0000, 0, 0, "lh");
        send(0, F3_HU, 32'h102, 0, 32'h00008899, 0, 4'b0000, 0, 0, "lhu");
        send(0, F3_W,  32'h100, 0, 32'h8899AABC, 0, 4'b0000, 0, 0, "lw");

        // Stores: byte/half lane replication and read-back.
        send(1, F3_B, 32'h103, 32'hFFFFFF5A, 0, 0, 4'b1000, 32'h5A5A5A5A, 0, "sb");
        send(0, F3_W, 32'h100, 0, 32'h5A99AABC, 0, 4'b0000, 0, 0, "lw_after_sb");
        send(1, F3_H, 32'h106, 32'hABCD1234, 0, 0, 4'b1100, 32'h12341234, 0, "sh");
        send(0, F3_W, 32'h104, 0, 32'h12340041, 0, 4'b0000, 0, 0, "lw_after_sh");
        send(1, F3_W, 32'h108, 32'hDEADBEEF, 0, 0, 4'b1111, 32'hDEADBEEF, 0, "sw");
        send(0, F3_W, 32'h108, 0, 32'hDEADBEEF, 0, 4'b0000, 0, 0, "lw_after_sw");

        // Errors interleaved with good loads must keep request order.
        send(0, F3_B,   32'h100, 0, 32'hFFFFFFBC, 0, 4'b0000, 0, 0, "lb_byte0");
        send(0, F3_W,   32'h102, 0, 32'h0,        1, 4'b0000, 0, 0, "lw_misalign");
        send(0, F3_BU,  32'h103, 0, 32'h0000005A, 0, 4'b0000, 0, 0, "lbu_byte3");
        send(1, F3_H,   32'h001, 32'h1111, 32'h0, 1, 4'b0000, 0, 0, "sh_misalign");
        send(0, F3_H,   32'h100, 0, 32'hFFFFAABC, 0, 4'b0000, 0, 0, "lh_low");
        send(0, 3'b011, 32'h100, 0, 32'h0,        1, 4'b0000, 0, 0, "ld_bad_f3");
        send(1, 3'b100, 32'h100, 32'h2222, 32'h0, 1, 4'b0000, 0, 0, "st_bad_f3");
        send(0, F3_W,   32'h100, 0, 32'h5A99AABC, 0, 4'b0000, 0, 0, "lw_after_err");
        drain();

        // Back-to-back loads: one fire per cycle, two-cycle response latency.
        @(posedge clk); #1;
        prev = 0;
        for (int i = 0; i < 8; i++) begin
            send(0, F3_W, 32'h110 + 32'(4*i), 0, 32'hC0DE0044 + 32'(i), 0, 4'b0000, 0, 1, "b2b");
            if (i > 0) chk("b2b_gap", 32'(last_fire - prev), 32'd1);
            prev = last_fire;
        end
        drain();

        // Backpressure: exactly RSP_DEPTH fires, then credit-limited.
        @(posedge clk); #1;
        bus.rsp_ready  = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_funct3 = F3_W;
        bus.req_addr   = 32'h130;
        nf = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                sb.push_back('{32'hC0DE004C + 32'(nf), 1'b0, cyc, 1'b0});
                nf++;
            end
            @(posedge clk); #1;
            bus.req_addr = 32'h130 + 32'(4*nf);
        end
        chk("bp_fires", 32'(nf), 32'd4);
        chk("bp_ready_low", 32'(bus.req_ready), 32'd0);
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_ready_before_pop", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        chk("bp_ready_after_pop", 32'(bus.req_ready), 32'd1);
        drain();

        // Reset with two loads in flight: nothing stale afterwards.
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        send(0, F3_W, 32'h100, 0, 32'h5A99AABC, 0, 4'b0000, 0, 0, "pre_rst0");
        send(0, F3_W, 32'h104, 0, 32'h12340041, 0, 4'b0000, 0, 0, "pre_rst1");
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("midrst_req_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("midrst_req_ready2", 32'(bus.req_ready), 32'd0);
        chk("midrst_rsp_rdata", bus.rsp_rdata, 32'd0);
        @(posedge clk); #1;
        reset         = 1'b0;
        bus.rsp_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("no_stale_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        @(posedge clk); #1;
        send(0, F3_W, 32'h100, 0, 32'h8899AABC, 0, 4'b0000, 0, 1, "lw_post_rst");
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
